fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `decode`. It owns the program counter, reads 16-bit instruction words from instruction memory over a req/ack handshake, and assembles one- or two-word instructions. It presents each instruction on `ins`/`ext`/`ins_en` to `decode`, and applies PC redirects (`set_pc`/`add_pc`) that come back from the decode/execute path.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the PC, fetches 16-bit words over a req/ack handshake, assembles
// one- or two-word instructions and applies redirects from decode/execute.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic        set_pc,
  input  logic        add_pc,
  input  logic [15:0] redir_val,
  output logic [15:0] ins,
  output logic [15:0] ext,
  output logic        ins_en,
  output logic [15:0] pc_out
);

  localparam logic [1:0] FETCH_INS = 2'd0;
  localparam logic [1:0] FETCH_EXT = 2'd1;
  localparam logic [1:0] PRESENT   = 2'd2;

  logic [1:0]  state;
  logic [15:0] fetch_addr;
  logic        squash;
  logic [15:0] squash_target;
  logic [15:0] ins_q;
  logic [15:0] ext_q;
  logic [15:0] pc_q;

  logic        redir;
  logic [15:0] target;
  logic        in_fetch;

  // Redirect request and its target; set_pc has priority over add_pc.
  always_comb begin
    redir  = set_pc | add_pc;
    target = set_pc ? redir_val : pc_q + redir_val;
  end

  // Output decode; reset forces the handshake and the instruction bus idle.
  always_comb begin
    in_fetch = (state == FETCH_INS) || (state == FETCH_EXT);
    mem_req  = in_fetch && !cpu_rst;
    mem_addr = cpu_rst ? RESET_PC : fetch_addr;
    ins_en   = (state == PRESENT) && !cpu_rst;
    ins      = cpu_rst ? '0 : ins_q;
    ext      = cpu_rst ? '0 : ext_q;
    pc_out   = cpu_rst ? RESET_PC : pc_q;
  end

  // Fetch FSM: request words, assemble instructions, handle redirects.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state         <= FETCH_INS;
      fetch_addr    <= RESET_PC;
      squash        <= 1'b0;
      squash_target <= RESET_PC;
      ins_q         <= '0;
      ext_q         <= '0;
      pc_q          <= RESET_PC;
    end else begin
      case (state)
        FETCH_INS, FETCH_EXT: begin
          if (mem_ack) begin
            // A redirect this cycle overrides any stored squash target.
            if (redir || squash) begin
              fetch_addr <= redir ? target : squash_target;
              squash     <= 1'b0;
              state      <= FETCH_INS;
            end else if (state == FETCH_INS) begin
              ins_q      <= mem_rdata;
              pc_q       <= fetch_addr;
              fetch_addr <= fetch_addr + 16'd1;
              if (mem_rdata[15]) begin
                state <= FETCH_EXT;
              end else begin
                ext_q <= '0;
                state <= PRESENT;
              end
            end else begin
              ext_q      <= mem_rdata;
              fetch_addr <= fetch_addr + 16'd1;
              state      <= PRESENT;
            end
          end else if (redir) begin
            // Request cannot be withdrawn: remember the target, drop the data later.
            squash        <= 1'b1;
            squash_target <= target;
          end
        end
        PRESENT: begin
          if (redir) begin
            fetch_addr <= target;
            state      <= FETCH_INS;
          end else if (!stall) begin
            state <= FETCH_INS;
          end
        end
        default: begin
          state <= FETCH_INS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        set_pc;
  logic        add_pc;
  logic [15:0] redir_val;
  logic [15:0] ins;
  logic [15:0] ext;
  logic        ins_en;
  logic [15:0] pc_out;

  logic        ack_gate;
  logic [15:0] mem [0:65535];

  typedef struct {
    logic [15:0] ins;
    logic [15:0] ext;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .cpu_clk   (clk),
    .cpu_rst   (cpu_rst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .set_pc    (set_pc),
    .add_pc    (add_pc),
    .redir_val (redir_val),
    .ins       (ins),
    .ext       (ext),
    .ins_en    (ins_en),
    .pc_out    (pc_out)
  );

  // Zero-wait memory, gated by ack_gate to create wait states.
  assign mem_ack   = mem_req & ack_gate;
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ins(input logic [15:0] i, input logic [15:0] e, input logic [15:0] p);
    exp_t x;
    x.ins = i; x.ext = e; x.pc = p;
    exp_q.push_back(x);
  endtask

  // Scoreboard monitor: checks accepted request addresses and consumed instructions.
  always @(negedge clk) begin
    if (!cpu_rst) begin
      if (mem_req && mem_ack) begin
        if (addr_q.size() == 0) chk("unexpected_req_addr", mem_addr, 16'hxxxx);
        else chk("req_addr", mem_addr, addr_q.pop_front());
      end
      if (ins_en && !stall && !set_pc && !add_pc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ins", ins, 16'hxxxx);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("sb_ins", ins, x.ins);
          chk("sb_ext", ext, x.ext);
          chk("sb_pc", pc_out, x.pc);
        end
      end
    end
  end

  // Reset for three edges; leaves the bench at the start of cycle 0.
  task automatic do_reset(input logic ag);
    cpu_rst = 1'b1; stall = 1'b0; set_pc = 1'b0; add_pc = 1'b0;
    redir_val = '0; ack_gate = ag;
    step(); step();
    #3;
    chk("rst_ins", ins, 16'h0000);
    chk("rst_ext", ext, 16'h0000);
    chk("rst_ins_en", 16'(ins_en), 16'h0000);
    chk("rst_pc_out", pc_out, RST_PC);
    chk("rst_mem_req", 16'(mem_req), 16'h0000);
    chk("rst_mem_addr", mem_addr, RST_PC);
    step();
    cpu_rst = 1'b0;
  endtask

  initial begin
    logic [7:0] en_pat;
    logic [7:0] req_pat;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    cpu_rst = 1'b1; stall = 1'b0; set_pc = 1'b0; add_pc = 1'b0;
    redir_val = '0; ack_gate = 1'b1;

    // One-word instructions back to back.
    mem[0] = 16'h1234; mem[1] = 16'h0042; mem[2] = 16'h0005;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0001);
    push_ins(16'h1234, 16'h0000, 16'h0000);
    push_ins(16'h0042, 16'h0000, 16'h0001);
    do_reset(1'b1);
    en_pat = 8'b0000_1010; req_pat = 8'b0001_0101;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) ack_gate = 1'b0;
      #3;
      chk("t1_ins_en", 16'(ins_en), 16'(en_pat[c]));
      chk("t1_mem_req", 16'(mem_req), 16'(req_pat[c]));
      if (c == 2) chk("t1_addr_c2", mem_addr, 16'h0001);
      step();
    end

    // Two-word instruction followed by a one-word one.
    mem[0] = 16'h8001; mem[1] = 16'hBEEF; mem[2] = 16'h0011;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0001); addr_q.push_back(16'h0002);
    push_ins(16'h8001, 16'hBEEF, 16'h0000);
    push_ins(16'h0011, 16'h0000, 16'h0002);
    do_reset(1'b1);
    en_pat = 8'b0001_0100; req_pat = 8'b0010_1011;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) ack_gate = 1'b0;
      #3;
      chk("t2_ins_en", 16'(ins_en), 16'(en_pat[c]));
      chk("t2_mem_req", 16'(mem_req), 16'(req_pat[c]));
      if (c == 3) chk("t2_next_addr", mem_addr, 16'h0002);
      step();
    end

    // Stall held for three cycles in PRESENT.
    mem[0] = 16'h1234; mem[1] = 16'h0042;
    addr_q.push_back(16'h0000);
    push_ins(16'h1234, 16'h0000, 16'h0000);
    do_reset(1'b1);
    for (int c = 0; c < 6; c++) begin
      stall = (c >= 1 && c <= 3);
      if (c == 5) ack_gate = 1'b0;
      #3;
      if (c >= 1 && c <= 3) begin
        chk("t3_ins_en", 16'(ins_en), 16'h0001);
        chk("t3_ins", ins, 16'h1234);
        chk("t3_ext", ext, 16'h0000);
        chk("t3_pc", pc_out, 16'h0000);
      end
      if (c >= 1 && c <= 4) chk("t3_no_req", 16'(mem_req), 16'h0000);
      if (c == 5) begin
        chk("t3_req_after", 16'(mem_req), 16'h0001);
        chk("t3_addr_after", mem_addr, 16'h0001);
      end
      step();
    end
    stall = 1'b0;

    // set_pc during a four-cycle wait: pending data dropped, target fetched.
    mem[0] = 16'h0077; mem[16'h0100] = 16'h0123; mem[16'h0101] = 16'h0003;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0100);
    push_ins(16'h0123, 16'h0000, 16'h0100);
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      set_pc = (c == 1);
      redir_val = (c == 1) ? 16'h0100 : 16'h0000;
      if (c == 4) ack_gate = 1'b1;
      if (c == 7) ack_gate = 1'b0;
      #3;
      if (c <= 4) begin
        chk("t4_req_held", 16'(mem_req), 16'h0001);
        chk("t4_addr_held", mem_addr, 16'h0000);
      end
      if (c == 4 || c == 5) chk("t4_no_present", 16'(ins_en), 16'h0000);
      if (c == 5) chk("t4_target_addr", mem_addr, 16'h0100);
      if (c == 6) chk("t4_present", 16'(ins_en), 16'h0001);
      if (c == 7) chk("t4_addr_next", mem_addr, 16'h0101);
      step();
    end
    set_pc = 1'b0;

    // Relative redirect wraps; also a stalled PRESENT is discarded.
    mem[0] = 16'h0000; mem[16'hFFFE] = 16'h0055; mem[16'hFFFF] = 16'h0066;
    addr_q.push_back(16'h0000); addr_q.push_back(16'hFFFE);
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      set_pc = (c == 0); add_pc = (c == 2); stall = (c == 2);
      redir_val = (c == 0) ? 16'hFFFE : 16'h0005;
      if (c == 3) ack_gate = 1'b0;
      #3;
      if (c == 1) chk("t5a_addr", mem_addr, 16'hFFFE);
      if (c == 2) begin
        chk("t5a_ins_en", 16'(ins_en), 16'h0001);
        chk("t5a_pc", pc_out, 16'hFFFE);
      end
      if (c == 3) begin
        chk("t5a_ins_en_drop", 16'(ins_en), 16'h0000);
        chk("t5a_wrap_addr", mem_addr, 16'h0003);
        chk("t5a_req", 16'(mem_req), 16'h0001);
      end
      step();
    end
    set_pc = 1'b0; add_pc = 1'b0; stall = 1'b0;

    // set_pc and add_pc together: set_pc wins.
    addr_q.push_back(16'h0000); addr_q.push_back(16'hFFFE);
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      set_pc = (c == 0 || c == 2); add_pc = (c == 2);
      redir_val = (c == 0) ? 16'hFFFE : 16'h0005;
      if (c == 3) ack_gate = 1'b0;
      #3;
      if (c == 3) chk("t5b_set_wins", mem_addr, 16'h0005);
      step();
    end
    set_pc = 1'b0; add_pc = 1'b0;

    // Fetch address wraps from FFFF to 0000.
    addr_q.push_back(16'h0000); addr_q.push_back(16'hFFFF);
    push_ins(16'h0066, 16'h0000, 16'hFFFF);
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      set_pc = (c == 0);
      redir_val = 16'hFFFF;
      if (c == 3) ack_gate = 1'b0;
      #3;
      if (c == 3) begin
        chk("t5c_req", 16'(mem_req), 16'h0001);
        chk("t5c_wrap_addr", mem_addr, 16'h0000);
      end
      step();
    end
    set_pc = 1'b0;

    // Reset while FETCH_EXT has a pending request.
    mem[0] = 16'h8001;
    addr_q.push_back(16'h0000); addr_q.push_back(16'h0000);
    push_ins(16'h0009, 16'h0000, 16'h0000);
    do_reset(1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c == 1) ack_gate = 1'b0;
      if (c == 2) cpu_rst = 1'b1;
      if (c == 4) begin cpu_rst = 1'b0; ack_gate = 1'b1; mem[0] = 16'h0009; end
      if (c == 6) ack_gate = 1'b0;
      #3;
      if (c == 1) begin
        chk("t6_ext_req", 16'(mem_req), 16'h0001);
        chk("t6_ext_addr", mem_addr, 16'h0001);
      end
      if (c == 2 || c == 3) begin
        chk("t6_rst_req", 16'(mem_req), 16'h0000);
        chk("t6_rst_ins_en", 16'(ins_en), 16'h0000);
      end
      if (c == 4) begin
        chk("t6_restart_req", 16'(mem_req), 16'h0001);
        chk("t6_restart_addr", mem_addr, RST_PC);
      end
      if (c == 5) chk("t6_ins_en", 16'(ins_en), 16'h0001);
      step();
    end

    chk("ins_queue_empty", 16'(exp_q.size()), 16'h0000);
    chk("addr_queue_empty", 16'(addr_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
